sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_target.sv | 197 +++++++++++++++++++
 tb/tb_sccb_target.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
`default_nettype none
// ============================================================================
// sccb_target : SCCB register-write target with 8-bit sub-address pointer.
//               Read-back is enabled by defining SCCB_TARGET_READ_EN.
// Rev 1.0
// ============================================================================
module sccb_target #(
    parameter logic [7:0] DEVICE_ADDR = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SIOC_in,
    input  logic       SIOD_in,
    output logic       SIOD_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ID        = 4'd1;
    localparam logic [3:0] S_ID_ACK    = 4'd2;
    localparam logic [3:0] S_SUB       = 4'd3;
    localparam logic [3:0] S_SUB_ACK   = 4'd4;
    localparam logic [3:0] S_DATA      = 4'd5;
    localparam logic [3:0] S_DATA_ACK  = 4'd6;
    localparam logic [3:0] S_RD        = 4'd7;
    localparam logic [3:0] S_RD_ACK    = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] r_sioc_sync, r_siod_sync;
    logic [SYNC_STAGES:0]   r_settle;
    logic                   r_scl_d, r_sda_d, r_bus_ok;
    logic [3:0]             r_state;
    logic [7:0]             r_shift, r_sub;
    logic [2:0]             r_bitcnt;
    logic                   r_phase, r_rnw;

    logic       w_scl, w_sda, w_start, w_stop, w_rise, w_fall, w_last;
    logic       w_id_match, w_id_read;
    logic [7:0] w_byte, w_rd_byte;

    assign w_scl   = r_sioc_sync[SYNC_STAGES-1];
    assign w_sda   = r_siod_sync[SYNC_STAGES-1];
    // START is only honoured once the synchronisers hold real bus values and
    // the bus has been seen idle, so a reset released mid-frame cannot fake one.
    assign w_start = r_bus_ok & w_scl & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & ~r_sda_d & w_sda;
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;
    assign w_byte  = {r_shift[6:0], w_sda};
    assign w_last  = (r_bitcnt == 3'd7);
    assign w_id_match = (w_byte[7:1] == DEVICE_ADDR[7:1]);
    assign busy    = (r_state != S_IDLE);

`ifdef SCCB_TARGET_READ_EN
    assign w_id_read = w_id_match & w_byte[0];
    assign w_rd_byte = rd_data;
`else
    logic w_unused_rd;
    assign w_id_read   = 1'b0;
    assign w_rd_byte   = 8'h00;
    assign w_unused_rd = ^rd_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sioc_sync <= '1;
            r_siod_sync <= '1;
            r_scl_d     <= 1'b1;
            r_sda_d     <= 1'b1;
            r_settle    <= '0;
            r_bus_ok    <= 1'b0;
        end else begin
            r_sioc_sync <= {r_sioc_sync[SYNC_STAGES-2:0], SIOC_in};
            r_siod_sync <= {r_siod_sync[SYNC_STAGES-2:0], SIOD_in};
            r_scl_d     <= w_scl;
            r_sda_d     <= w_sda;
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            r_bus_ok    <= r_bus_ok | (r_settle[SYNC_STAGES] & w_scl & w_sda);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            SIOD_oe  <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            rd_addr  <= 8'h00;
            r_sub    <= 8'h00;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_phase  <= 1'b0;
            r_rnw    <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= S_ID;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
                SIOD_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_phase  <= 1'b0;
                SIOD_oe  <= 1'b0;
            end else begin
                case (r_state)
                    S_ID, S_SUB, S_DATA: begin
                        if (w_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) begin
                                case (r_state)
                                    S_ID: begin
                                        r_rnw <= w_byte[0];
                                        if ((w_id_match && !w_byte[0]) || w_id_read)
                                            r_state <= S_ID_ACK;
                                        else
                                            r_state <= S_WAIT_STOP;
                                    end
                                    S_SUB: begin
                                        r_sub   <= w_byte;
                                        rd_addr <= w_byte;
                                        r_state <= S_SUB_ACK;
                                    end
                                    default: begin
                                        wr_valid <= 1'b1;
                                        wr_addr  <= r_sub;
                                        wr_data  <= w_byte;
                                        r_state  <= S_DATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // First fall pulls SIOD low, the fall after the 9th rise releases it.
                    S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                        if (w_fall) begin
                            if (!r_phase) begin
                                SIOD_oe <= 1'b1;
                                r_phase <= 1'b1;
                            end else begin
                                SIOD_oe  <= 1'b0;
                                r_phase  <= 1'b0;
                                r_bitcnt <= 3'd0;
                                case (r_state)
                                    S_ID_ACK: begin
                                        if (r_rnw) begin
                                            SIOD_oe <= ~w_rd_byte[7];
                                            r_shift <= {w_rd_byte[6:0], 1'b0};
                                            r_state <= S_RD;
                                        end else begin
                                            r_state <= S_SUB;
                                        end
                                    end
                                    S_SUB_ACK: r_state <= S_DATA;
                                    default:   r_state <= S_WAIT_STOP;
                                endcase
                            end
                        end
                    end
                    S_RD: begin
                        if (w_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last)
                                r_phase <= 1'b1;
                        end else if (w_fall) begin
                            if (r_phase) begin
                                SIOD_oe <= 1'b0;
                                r_phase <= 1'b0;
                                r_state <= S_RD_ACK;
                            end else begin
                                SIOD_oe <= ~r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_rise)
                            r_state <= S_WAIT_STOP;
                    end
                    default: begin
                        SIOD_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sccb_target : bus-level master driving sccb_target against a transaction model.
// Rev 1.0
// ============================================================================
module tb_sccb_target;

    localparam int         SYNC = 2;
    localparam int         Q    = 50;
    localparam logic [6:0] DEV7 = 7'h21;
`ifdef SCCB_TARGET_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       SIOC_in, SIOD_in, SIOD_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [7:0] regs [256];

    assign SIOC_in = m_scl;
    assign SIOD_in = m_sda & ~SIOD_oe;
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    sccb_target #(.DEVICE_ADDR(8'h42), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .SIOC_in(SIOC_in), .SIOD_in(SIOD_in),
        .SIOD_oe(SIOD_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [7:0]  m_last_addr = 8'h00, m_last_data = 8'h00, m_ptr = 8'h00;
    bit          exp_silent = 1'b0;
    int          obs_count = 0;
    logic [7:0]  obs_addr = 8'h00, obs_data = 8'h00;
    int          last_acks = 0;
    logic [7:0]  last_read = 8'h00;
    logic        prev_scl = 1'b1, prev_oe = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_strobe unexpected: addr=%h data=%h", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        failures++;
                        $display("FAIL wr_strobe: got %h/%h want %h/%h", wr_addr, wr_data, e[15:8], e[7:0]);
                    end
                    m_last_addr = e[15:8];
                    m_last_data = e[7:0];
                end
                obs_count++;
                obs_addr = wr_addr;
                obs_data = wr_data;
            end else if (wr_addr !== m_last_addr || wr_data !== m_last_data) begin
                failures++;
                $display("FAIL wr_hold: got %h/%h want %h/%h", wr_addr, wr_data, m_last_addr, m_last_data);
            end
            checks++;
            if (exp_silent && SIOD_oe !== 1'b0) begin
                failures++;
                $display("FAIL oe_silent: got %b want 0", SIOD_oe);
            end
            checks++;
            if (m_scl && prev_scl && SIOD_oe !== prev_oe) begin
                failures++;
                $display("FAIL oe_stable_sioc_high: got %b want %b", SIOD_oe, prev_oe);
            end
        end
        prev_scl = m_scl;
        prev_oe  = SIOD_oe;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic clk_bit(input bit b, output bit s);
        m_sda = b;
        #(Q); m_scl = 1'b1;
        #(Q); s = SIOD_in;
        #(Q); m_scl = 1'b0;
        #(Q);
    endtask

    task automatic do_start();
        if (m_scl) begin
            m_sda = 1'b0; #(Q); m_scl = 1'b0; #(Q);
        end else begin
            m_sda = 1'b1; #(Q); m_scl = 1'b1; #(Q);
            m_sda = 1'b0; #(Q); m_scl = 1'b0; #(Q);
        end
    endtask

    task automatic do_stop();
        bit ok;
        ok = 1'b0;
        m_sda = 1'b0; #(Q); m_scl = 1'b1; #(Q); m_sda = 1'b1;
        for (int i = 0; i < SYNC + 2; i++) begin
            #10;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy_after_stop", {31'd0, ok}, 32'd1);
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, output bit acked);
        bit s;
        acked = 1'b0;
        for (int i = 0; i < nbits; i++) clk_bit(b[7-i], s);
        if (nbits == 8) begin
            clk_bit(1'b1, s);
            acked = ~s;
        end
    endtask

    task automatic finish_txn(input bit rstart);
        if (!rstart) do_stop();
        check("strobe_pending", exp_q.size(), 0);
        exp_q.delete();
        check("rd_addr_ptr", {24'd0, rd_addr}, {24'd0, m_ptr});
        exp_silent = 1'b0;
    endtask

    task automatic run_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                             input int nbytes, input int abort_bits, input bit rstart);
        logic [7:0] bs [5];
        bit ok, acked, exp_ack;
        int nb;
        bs[0] = id; bs[1] = sub; bs[2] = dat;
        bs[3] = 8'($urandom); bs[4] = 8'($urandom);
        ok = (id[7:1] == DEV7) && !id[0];
        exp_silent = !ok;
        last_acks = 0;
        do_start();
        for (int k = 0; k < nbytes; k++) begin
            nb = (k == nbytes - 1) ? abort_bits : 8;
            if (ok && k == 2 && nb == 8) exp_q.push_back({sub, dat});
            send_byte(bs[k], nb, acked);
            if (nb == 8) begin
                exp_ack = ok && (k < 3);
                check($sformatf("ack_byte%0d", k), {31'd0, acked}, {31'd0, exp_ack});
                if (acked) last_acks++;
                if (ok && k == 1) m_ptr = sub;
            end
        end
        finish_txn(rstart);
    endtask

    task automatic run_read(input logic [7:0] id, input bit rstart);
        bit ok, acked, s;
        logic [7:0] rb;
        ok = READ_EN && (id[7:1] == DEV7) && id[0];
        exp_silent = !ok;
        last_acks = 0;
        do_start();
        send_byte(id, 8, acked);
        check("ack_read_id", {31'd0, acked}, {31'd0, ok});
        if (acked) last_acks++;
        if (ok) begin
            rb = 8'h00;
            for (int i = 0; i < 8; i++) begin
                clk_bit(1'b1, s);
                rb = {rb[6:0], s};
            end
            clk_bit(1'b1, s);
            check("read_byte", {24'd0, rb}, {24'd0, regs[m_ptr]});
            last_read = rb;
        end
        finish_txn(rstart);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s, acked;
        logic [7:0] id, tmp;
        int r, nbytes, abort_bits;
        bit rstart;

        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        regs[8'h0A] = 8'h76;

        #23;
        check("reset_outputs", {18'd0, SIOD_oe, wr_valid, wr_addr, wr_data, busy},
              {18'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
        check("reset_rd_addr", {24'd0, rd_addr}, 32'h00);
        reset_n = 1'b1;
        #(2*Q);

        // Three-phase write to the own ID.
        run_write(8'h42, 8'h12, 8'h80, 3, 8, 1'b0);
        check("w3_acks", last_acks, 3);
        check("w3_strobe", {obs_count[15:0], obs_addr, obs_data}, {16'd1, 8'h12, 8'h80});

        // Foreign ID followed by SUB/DATA: silent, no strobe.
        run_write(8'h60, 8'h33, 8'h55, 3, 8, 1'b0);
        check("foreign_acks", last_acks, 0);
        check("foreign_nostrobe", obs_count, 1);

        // STOP after 5 bits of data byte.
        run_write(8'h42, 8'h21, 8'hC3, 3, 5, 1'b0);
        check("abort_nostrobe", obs_count, 1);
        check("abort_ptr", {24'd0, rd_addr}, 32'h21);

        // Two-phase pointer write then read ID.
        run_write(8'h42, 8'h0A, 8'h00, 2, 8, 1'b0);
        check("ptr_0A", {24'd0, rd_addr}, 32'h0A);
        run_read(8'h43, 1'b0);
        if (READ_EN) begin
            check("read_acks", last_acks, 1);
            check("read_76", {24'd0, last_read}, 32'h76);
        end else begin
            check("read_id_nack", last_acks, 0);
        end

        // Reset asserted in the middle of the SUB byte.
        do_start();
        exp_silent = 1'b0;
        send_byte(8'h42, 8, acked);
        check("rst_test_id_ack", {31'd0, acked}, 32'd1);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        reset_n = 1'b0;
        m_last_addr = 8'h00; m_last_data = 8'h00; m_ptr = 8'h00;
        exp_silent = 1'b1;
        #1;
        check("midsub_reset", {17'd0, SIOD_oe, wr_valid, wr_addr, wr_data, rd_addr[4:0], busy},
              {17'd0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b0});
        check("midsub_reset_rd_addr", {24'd0, rd_addr}, 32'h00);
        #9;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        check("post_reset_ignored", {30'd0, s, busy}, {30'd0, 1'b1, 1'b0});
        send_byte(8'h99, 8, acked);
        check("post_reset_nack", {31'd0, acked}, 32'd0);
        finish_txn(1'b0);
        run_write(8'h42, 8'h34, 8'h9C, 3, 8, 1'b0);
        check("after_reset_write", {obs_addr, obs_data}, {8'h34, 8'h9C});

        // Randomised traffic.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            rstart = ($urandom_range(0, 3) == 0) && (n < 29);
            tmp = 8'($urandom);
            if (r < 2) begin
                id = (r == 0) ? 8'h43 : {tmp[6:0], 1'b1};
                run_read(id, rstart);
            end else begin
                id = (r < 8) ? 8'h42 : {tmp[6:0], 1'b0};
                nbytes = $urandom_range(2, 5);
                abort_bits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
                run_write(id, 8'($urandom), 8'($urandom), nbytes, abort_bits, rstart);
            end
        end

        #200;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
